fsm_output_signature_monitor: RTL and testbench

// Downstream consumer of a 25-output control FSM's output word. Samples y1..y25 each enabled

---
 rtl/fsm_output_signature_monitor.sv | 110 +++++++++++
 tb/tb_fsm_output_signature_monitor.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/fsm_output_signature_monitor.sv
// Output-word monitor for a control FSM: compresses a fixed window of sampled words into a
// MISR signature, counts all-zero words, and flags over-long zero runs as a sticky dropout alarm.
module fsm_output_signature_monitor #(
    parameter int unsigned   W        = 25,
    parameter logic [W-1:0]  POLY     = 25'h0000009,
    parameter int unsigned   WIN_LEN  = 256,
    parameter int unsigned   ZRUN_MAX = 4,
    parameter int unsigned   CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic             en,
    input  logic [W-1:0]     y_in,
    input  logic             sig_ack,
    output logic             busy,
    output logic             sig_valid,
    output logic [W-1:0]     sig_out,
    output logic [CNT_W-1:0] zero_words,
    output logic             alarm
);

    localparam int unsigned SCNT_W = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1;
    localparam int unsigned RUN_W  = $clog2(ZRUN_MAX + 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e            state_q, state_d;
    logic [W-1:0]      misr_q;
    logic [SCNT_W-1:0] sample_cnt_q;
    logic [RUN_W-1:0]  run_len_q;

    logic [W-1:0]      misr_next;
    logic [RUN_W-1:0]  run_len_next;
    logic              sample_fire;
    logic              last_sample;

    assign misr_next   = {misr_q[W-2:0], 1'b0} ^ (misr_q[W-1] ? POLY : '0) ^ y_in;
    assign sample_fire = (state_q == StRun) && en && !abort;
    assign last_sample = (sample_cnt_q == SCNT_W'(WIN_LEN - 1));

    always_comb begin
        run_len_next = '0;
        if (y_in == '0) begin
            run_len_next = (run_len_q == RUN_W'(ZRUN_MAX)) ? run_len_q : run_len_q + RUN_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle:  if (start) state_d = StRun;
                StRun:   if (en && last_sample) state_d = StDone;
                StDone:  if (sig_ack) state_d = StIdle;
                default: state_d = StIdle;
            endcase
        end
    end

    always_comb begin
        busy      = (state_q == StRun);
        sig_valid = (state_q == StDone);
    end

    // Abort freezes the datapath: nothing is cleared or exported on an abandoned window.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            misr_q       <= '0;
            sample_cnt_q <= '0;
            run_len_q    <= '0;
            zero_words   <= '0;
            alarm        <= 1'b0;
            sig_out      <= '0;
        end else if (!abort) begin
            if (state_q == StIdle && start) begin
                misr_q       <= '0;
                sample_cnt_q <= '0;
                run_len_q    <= '0;
                zero_words   <= '0;
                alarm        <= 1'b0;
            end else if (sample_fire) begin
                misr_q       <= misr_next;
                sample_cnt_q <= sample_cnt_q + SCNT_W'(1);
                run_len_q    <= run_len_next;
                if (y_in == '0 && zero_words != '1) begin
                    zero_words <= zero_words + CNT_W'(1);
                end
                if (run_len_next == RUN_W'(ZRUN_MAX)) begin
                    alarm <= 1'b1;
                end
                if (last_sample) begin
                    sig_out <= misr_next;
                end
            end
        end
    end

endmodule

// File: tb/tb_fsm_output_signature_monitor.sv
// Bench for fsm_output_signature_monitor: directed scenarios plus random windows, checked every
// cycle against a window-level reference model (word list -> signature, zero count, zero runs).
module tb_fsm_output_signature_monitor;

    localparam int unsigned  W        = 25;
    localparam logic [W-1:0] POLY     = 25'h0000009;
    localparam int unsigned  WIN_LEN  = 8;
    localparam int unsigned  ZRUN_MAX = 4;
    localparam int unsigned  CNT_W    = 3;

    logic             clk = 1'b0;
    logic             rst, start, abort, en, sig_ack;
    logic [W-1:0]     y_in;
    logic             busy, sig_valid, alarm;
    logic [W-1:0]     sig_out;
    logic [CNT_W-1:0] zero_words;

    fsm_output_signature_monitor #(
        .W(W), .POLY(POLY), .WIN_LEN(WIN_LEN), .ZRUN_MAX(ZRUN_MAX), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .en(en), .y_in(y_in),
        .sig_ack(sig_ack), .busy(busy), .sig_valid(sig_valid), .sig_out(sig_out),
        .zero_words(zero_words), .alarm(alarm)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: phase 0=idle 1=collecting 2=result presented; words = samples taken this window.
    int           phase;
    logic [W-1:0] words[$];
    logic [W-1:0] exp_sig;

    // Multiply a GF(2) polynomial by x modulo x^25+x^3+1.
    function automatic logic [W-1:0] times_x(input logic [W-1:0] a);
        logic [W:0] p;
        p = {a, 1'b0};
        if (p[W]) p = p ^ {1'b1, POLY};
        return p[W-1:0];
    endfunction

    // Signature = sum of w_i * x^(n-1-i) mod P.
    function automatic logic [W-1:0] window_sig();
        logic [W-1:0] acc, term;
        acc = '0;
        for (int i = 0; i < words.size(); i++) begin
            term = words[i];
            for (int k = 0; k < words.size() - 1 - i; k++) term = times_x(term);
            acc = acc ^ term;
        end
        return acc;
    endfunction

    function automatic int unsigned exp_zeros();
        int unsigned c = 0;
        foreach (words[i]) if (words[i] == '0) c++;
        return (c > (2 ** CNT_W) - 1) ? (2 ** CNT_W) - 1 : c;
    endfunction

    function automatic logic exp_alarm();
        int unsigned run = 0;
        logic a = 1'b0;
        foreach (words[i]) begin
            run = (words[i] == '0) ? run + 1 : 0;
            if (run >= ZRUN_MAX) a = 1'b1;
        end
        return a;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string ctx);
        chk({ctx, " busy"}, 32'(busy), 32'(phase == 1));
        chk({ctx, " sig_valid"}, 32'(sig_valid), 32'(phase == 2));
        chk({ctx, " sig_out"}, 32'(sig_out), 32'(exp_sig));
        chk({ctx, " zero_words"}, 32'(zero_words), 32'(exp_zeros()));
        chk({ctx, " alarm"}, 32'(alarm), 32'(exp_alarm()));
    endtask

    task automatic model_reset();
        phase = 0;
        words.delete();
        exp_sig = '0;
    endtask

    // Apply inputs for one cycle, advance the model, then sample just after the edge.
    task automatic cycle(input string ctx, input logic s, input logic a, input logic e,
                         input logic [W-1:0] y, input logic k);
        start = s; abort = a; en = e; y_in = y; sig_ack = k;
        if (a) begin
            phase = 0;
        end else begin
            case (phase)
                0: if (s) begin words.delete(); phase = 1; end
                1: if (e) begin
                    words.push_back(y);
                    if (words.size() == WIN_LEN) begin exp_sig = window_sig(); phase = 2; end
                end
                default: if (k) phase = 0;
            endcase
        end
        @(posedge clk);
        #1;
        check_all(ctx);
    endtask

    task automatic feed(input string ctx, input logic [W-1:0] y);
        cycle(ctx, 1'b0, 1'b0, 1'b1, y, 1'b0);
    endtask

    task automatic idle(input string ctx);
        cycle(ctx, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; en = 1'b0; y_in = '0; sig_ack = 1'b0;
        model_reset();
        #12;
        check_all("reset");
        rst = 1'b0;
        idle("post_reset");

        // Single nonzero word then zeros; long zero tail raises the alarm and saturates count.
        cycle("t1_start", 1'b1, 1'b0, 1'b0, '0, 1'b0);
        feed("t1", 25'h0000400);
        for (int i = 0; i < WIN_LEN - 1; i++) feed("t1", '0);
        chk("t1_sig_out_direct", 32'(sig_out), 32'h0020000);
        cycle("t1_ack", 1'b0, 1'b0, 1'b0, '0, 1'b1);

        // MSB feedback path.
        cycle("t2_start", 1'b1, 1'b0, 1'b0, '0, 1'b0);
        feed("t2", 25'h1000000);
        feed("t2", '0);
        feed("t2", '0);
        for (int i = 0; i < WIN_LEN - 3; i++) feed("t2", 25'h0000001);
        cycle("t2_ack", 1'b0, 1'b0, 1'b0, '0, 1'b1);

        // Alarm sticks through later nonzero words.
        cycle("t3_start", 1'b1, 1'b0, 1'b0, '0, 1'b0);
        feed("t3", 25'h1);
        for (int i = 0; i < 4; i++) feed("t3_zero", '0);
        chk("t3_alarm_after_5th", 32'(alarm), 32'd1);
        feed("t3", 25'h1);
        feed("t3", '0);
        feed("t3", '0);

        // Held result with junk samples and no ack, then ack.
        for (int i = 0; i < 5; i++) cycle("t4_hold", 1'b1, 1'b0, 1'b1, '1, 1'b0);
        cycle("t4_ack", 1'b0, 1'b0, 1'b1, '1, 1'b1);
        cycle("t4_start", 1'b1, 1'b0, 1'b0, '0, 1'b0);
        for (int i = 0; i < WIN_LEN; i++) begin
            feed("t4_gap", (i == 0) ? 25'h0000400 : 25'h0);
            for (int g = 0; g < 3; g++) cycle("t4_gap_idle", 1'b0, 1'b0, 1'b0, '1, 1'b0);
        end
        cycle("t4_ack2", 1'b0, 1'b0, 1'b0, '0, 1'b1);

        // Asynchronous reset mid-window.
        cycle("t5_start", 1'b1, 1'b0, 1'b0, '0, 1'b0);
        for (int i = 0; i < 4; i++) feed("t5", '0);
        #3 rst = 1'b1;
        #1;
        model_reset();
        check_all("t5_async_rst");
        #1 rst = 1'b0;
        cycle("t5_restart", 1'b1, 1'b0, 1'b0, '0, 1'b0);
        feed("t5", 25'h0000400);
        for (int i = 0; i < WIN_LEN - 1; i++) feed("t5", '0);

        // Abort with result pending; start ignored while running; start clears alarm.
        cycle("t6_abort_done", 1'b0, 1'b1, 1'b0, '0, 1'b0);
        cycle("t6_start", 1'b1, 1'b0, 1'b0, '0, 1'b0);
        for (int i = 0; i < 4; i++) cycle("t6_run_start", 1'b1, 1'b0, 1'b1, '0, 1'b0);
        cycle("t6_abort_run", 1'b0, 1'b1, 1'b1, '0, 1'b0);
        idle("t6_idle");
        cycle("t6_clear", 1'b1, 1'b0, 1'b0, '0, 1'b0);

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            logic s, a, e, k;
            logic [W-1:0] y;
            s = ($urandom_range(0, 3) == 0);
            a = ($urandom_range(0, 59) == 0);
            e = ($urandom_range(0, 9) < 7);
            k = ($urandom_range(0, 2) == 0);
            y = ($urandom_range(0, 1) == 0) ? '0 : W'($urandom);
            cycle("rand", s, a, e, y, k);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
